// File: rtl/mult_pkg.sv
// Shared types and sizing helpers for the iterative multiplier.
// The FSM encoding and step/counter sizing are derived from WIDTH and BITS_PER_CYCLE.
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mult_state_t;

  // Number of BUSY cycles needed to retire every multiplier bit.
  function automatic int num_steps(input int width, input int bits_per_cycle);
    return width / bits_per_cycle;
  endfunction

  // Counter must hold N-1; keep at least one bit for the degenerate N=1 case.
  function automatic int cnt_width(input int width, input int bits_per_cycle);
    int n;
    n = width / bits_per_cycle;
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mult_step.sv
// One radix-2^BITS_PER_CYCLE shift-add step: adds the partial products selected by
// the low multiplier bits into the top of the accumulator, then shifts right.
module mult_step
  import mult_pkg::*;
#(
  parameter int WIDTH          = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic [2*WIDTH-1:0]        acc,
  input  logic [WIDTH-1:0]          mcand,
  input  logic [BITS_PER_CYCLE-1:0] mplier_bits,
  output logic [2*WIDTH-1:0]        acc_next
);

  localparam int PPW = WIDTH + BITS_PER_CYCLE;
  localparam int SW  = 2 * WIDTH + BITS_PER_CYCLE;

  logic [PPW-1:0] pp [BITS_PER_CYCLE];
  logic [PPW-1:0] pp_sum;
  logic [SW-1:0]  sum;

  for (genvar gi = 0; gi < BITS_PER_CYCLE; gi++) begin : g_pp
    assign pp[gi] = mplier_bits[gi] ? (PPW'(mcand) << gi) : '0;
  end

  // Sum of mcand*bits is below 2^(WIDTH+BITS_PER_CYCLE), so PPW bits never overflow.
  always_comb begin
    pp_sum = '0;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      pp_sum = pp_sum + pp[i];
    end
  end

  // The extra top bits absorb the carry; after the shift the value fits 2*WIDTH again.
  assign sum      = SW'(acc) + {pp_sum, {WIDTH{1'b0}}};
  assign acc_next = sum[SW-1:BITS_PER_CYCLE];

endmodule

// File: rtl/iter_multiplier.sv
// Fixed-latency iterative integer multiplier for the EX stage; drives mul_stall
// until the sign-corrected 2*WIDTH-bit product is registered.
module iter_multiplier
  import mult_pkg::*;
#(
  parameter int WIDTH          = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             is_signed,
  input  logic             flush,
  input  logic [0:WIDTH-1] op_a,
  input  logic [0:WIDTH-1] op_b,
  output logic             stall,
  output logic             done,
  output logic [WIDTH-1:0] product_hi,
  output logic [WIDTH-1:0] product_lo
);

  localparam int N  = num_steps(WIDTH, BITS_PER_CYCLE);
  localparam int CW = cnt_width(WIDTH, BITS_PER_CYCLE);

  mult_state_t          state_reg;
  logic [CW-1:0]        cnt_reg;
  logic [WIDTH-1:0]     mcand_reg;
  logic [WIDTH-1:0]     mplier_reg;
  logic [2*WIDTH-1:0]   acc_reg;
  logic                 neg_reg;
  logic                 done_reg;
  logic [WIDTH-1:0]     product_hi_reg;
  logic [WIDTH-1:0]     product_lo_reg;

  logic [WIDTH-1:0]     a_vec;
  logic [WIDTH-1:0]     b_vec;
  logic [WIDTH-1:0]     a_mag;
  logic [WIDTH-1:0]     b_mag;
  logic [2*WIDTH-1:0]   acc_next;
  logic [2*WIDTH-1:0]   product_next;

  // Whole-vector copies: op_a[0] (the MSB) lands in a_vec[WIDTH-1].
  assign a_vec = op_a;
  assign b_vec = op_b;

  // -(-2^(WIDTH-1)) wraps back to 2^(WIDTH-1), which is the correct unsigned magnitude.
  assign a_mag = (is_signed && a_vec[WIDTH-1]) ? (~a_vec + 1'b1) : a_vec;
  assign b_mag = (is_signed && b_vec[WIDTH-1]) ? (~b_vec + 1'b1) : b_vec;

  mult_step #(
    .WIDTH          (WIDTH),
    .BITS_PER_CYCLE (BITS_PER_CYCLE)
  ) u_step (
    .acc         (acc_reg),
    .mcand       (mcand_reg),
    .mplier_bits (mplier_reg[BITS_PER_CYCLE-1:0]),
    .acc_next    (acc_next)
  );

  assign product_next = neg_reg ? (~acc_next + 1'b1) : acc_next;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg      <= IDLE;
      cnt_reg        <= '0;
      mcand_reg      <= '0;
      mplier_reg     <= '0;
      acc_reg        <= '0;
      neg_reg        <= 1'b0;
      done_reg       <= 1'b0;
      product_hi_reg <= '0;
      product_lo_reg <= '0;
    end else if (flush) begin
      state_reg <= IDLE;
      done_reg  <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          done_reg <= 1'b0;
          if (start) begin
            mcand_reg  <= a_mag;
            mplier_reg <= b_mag;
            neg_reg    <= is_signed & (a_vec[WIDTH-1] ^ b_vec[WIDTH-1]);
            acc_reg    <= '0;
            cnt_reg    <= CW'(N - 1);
            state_reg  <= BUSY;
          end
        end
        BUSY: begin
          acc_reg    <= acc_next;
          mplier_reg <= mplier_reg >> BITS_PER_CYCLE;
          if (cnt_reg == '0) begin
            // Final step: fold the sign fix-up in so the result is visible in DONE.
            product_hi_reg <= product_next[2*WIDTH-1:WIDTH];
            product_lo_reg <= product_next[WIDTH-1:0];
            done_reg       <= 1'b1;
            state_reg      <= DONE;
          end else begin
            cnt_reg <= cnt_reg - 1'b1;
          end
        end
        DONE: begin
          done_reg  <= 1'b0;
          state_reg <= IDLE;
        end
        default: begin
          done_reg  <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

  // Stall drops in DONE so the instruction leaves EX together with its result.
  assign stall      = ~flush & (((state_reg == IDLE) & start) | (state_reg == BUSY));
  assign done       = done_reg & ~flush;
  assign product_hi = product_hi_reg;
  assign product_lo = product_lo_reg;

endmodule

// File: tb/tb_iter_multiplier.sv
// Bench for iter_multiplier: directed cases plus random operands against a 64-bit
// arithmetic reference, on instances with 1, 2 and 4 bits retired per cycle.
module tb_iter_multiplier;

  logic        clock = 1'b0;
  logic        reset;
  logic        flush;
  logic        start_v [3];
  logic        sg_v    [3];
  logic [31:0] a_v     [3];
  logic [31:0] b_v     [3];
  logic        stall_v [3];
  logic        done_v  [3];
  logic [31:0] hi_v    [3];
  logic [31:0] lo_v    [3];

  int compared = 0;
  int mismatched = 0;

  always #5 clock = ~clock;

  for (genvar gi = 0; gi < 3; gi++) begin : g_dut
    iter_multiplier #(
      .WIDTH          (32),
      .BITS_PER_CYCLE (1 << gi)
    ) u_dut (
      .clock      (clock),
      .reset      (reset),
      .start      (start_v[gi]),
      .is_signed  (sg_v[gi]),
      .flush      (flush),
      .op_a       (a_v[gi]),
      .op_b       (b_v[gi]),
      .stall      (stall_v[gi]),
      .done       (done_v[gi]),
      .product_hi (hi_v[gi]),
      .product_lo (lo_v[gi])
    );
  end

  // Reference: sign- or zero-extend to 64 bits and multiply modulo 2^64.
  function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b,
                                          input logic sg);
    logic [63:0] ea;
    logic [63:0] eb;
    ea = sg ? {{32{a[31]}}, a} : {32'h0, a};
    eb = sg ? {{32{b[31]}}, b} : {32'h0, b};
    return ea * eb;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Issue one multiply on instance k, measure stall cycles, check the result and done pulse.
  task automatic do_mul(input int k, input logic [31:0] a, input logic [31:0] b,
                        input logic sg, input logic [63:0] exp, input string tag);
    int cyc;
    bit got;
    cyc = 0;
    got = 0;
    @(posedge clock); #1;
    a_v[k] = a; b_v[k] = b; sg_v[k] = sg; start_v[k] = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clock);
      if (done_v[k]) begin
        got = 1;
        break;
      end
      if (stall_v[k]) cyc++;
    end
    check({tag, " done_seen"}, 64'(got), 64'd1);
    if (got) begin
      check({tag, " latency"}, 64'(cyc), 64'(1 + 32 / (1 << k)));
      check({tag, " stall_in_done"}, 64'(stall_v[k]), 64'd0);
      check({tag, " product"}, {hi_v[k], lo_v[k]}, exp);
    end
    $display("op k=%0d a=%h b=%h signed=%0d hi=%h lo=%h stall_cycles=%0d", k, a, b, sg,
             hi_v[k], lo_v[k], cyc);
    @(posedge clock); #1;
    start_v[k] = 1'b0;
    @(negedge clock);
    check({tag, " done_one_cycle"}, 64'(done_v[k]), 64'd0);
  endtask

  initial begin
    int t0, t1, ndone, lows, seen;
    logic [63:0] prev;
    logic [31:0] ra, rb;
    logic rs;

    reset = 1'b1;
    flush = 1'b0;
    for (int k = 0; k < 3; k++) begin
      start_v[k] = 1'b0; sg_v[k] = 1'b0; a_v[k] = '0; b_v[k] = '0;
    end
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("reset_stall k%0d", k), 64'(stall_v[k]), 64'd0);
      check($sformatf("reset_done k%0d", k), 64'(done_v[k]), 64'd0);
      check($sformatf("reset_prod k%0d", k), {hi_v[k], lo_v[k]}, 64'd0);
    end

    do_mul(0, 32'h00000003, 32'h00000005, 1'b0, 64'h00000000_0000000F, "multu_3x5");
    do_mul(0, 32'hFFFFFFFF, 32'h00000002, 1'b1, 64'hFFFFFFFF_FFFFFFFE, "mult_m1x2");
    do_mul(0, 32'hFFFFFFFF, 32'h00000002, 1'b0, 64'h00000001_FFFFFFFE, "multu_ffx2");
    do_mul(0, 32'h80000000, 32'h80000000, 1'b1, 64'h40000000_00000000, "mult_min_sq");
    do_mul(0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 64'hFFFFFFFE_00000001, "multu_max_sq");

    // Back-to-back: start stays high, second operands presented right after DONE.
    @(posedge clock); #1;
    a_v[0] = 32'd7; b_v[0] = 32'd9; sg_v[0] = 1'b0; start_v[0] = 1'b1;
    ndone = 0; lows = 0; t0 = 0; t1 = 0;
    for (int i = 0; i < 150; i++) begin
      @(negedge clock);
      if (done_v[0]) begin
        if (ndone == 0) begin
          t0 = i;
          check("b2b first_product", {hi_v[0], lo_v[0]}, 64'd63);
          ndone = 1;
          lows++;
          @(posedge clock); #1;
          a_v[0] = 32'hFFFFFFF9; b_v[0] = 32'd6; sg_v[0] = 1'b1;
          continue;
        end else begin
          t1 = i;
          check("b2b second_product", {hi_v[0], lo_v[0]}, 64'hFFFFFFFF_FFFFFFD6);
          ndone = 2;
          break;
        end
      end
      if (ndone == 1 && !stall_v[0]) lows++;
    end
    check("b2b done_count", 64'(ndone), 64'd2);
    check("b2b done_spacing", 64'(t1 - t0), 64'd34);
    check("b2b stall_low_cycles", 64'(lows), 64'd1);
    $display("b2b done at %0d and %0d, stall low %0d cycle(s)", t0, t1, lows);
    @(posedge clock); #1 start_v[0] = 1'b0;

    // Flush in the tenth BUSY cycle.
    prev = {hi_v[0], lo_v[0]};
    @(posedge clock); #1;
    a_v[0] = 32'h1234; b_v[0] = 32'h10; sg_v[0] = 1'b0; start_v[0] = 1'b1;
    repeat (10) @(posedge clock);
    #1 flush = 1'b1;
    @(negedge clock);
    check("flush stall_same_cycle", 64'(stall_v[0]), 64'd0);
    check("flush done_same_cycle", 64'(done_v[0]), 64'd0);
    @(posedge clock); #1;
    flush = 1'b0; start_v[0] = 1'b0;
    @(negedge clock);
    check("flush idle_next", 64'(stall_v[0]), 64'd0);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (done_v[0] || stall_v[0]) seen++;
    end
    check("flush no_activity", 64'(seen), 64'd0);
    check("flush product_kept", {hi_v[0], lo_v[0]}, prev);
    $display("flush at busy cycle 10, product kept hi=%h lo=%h", hi_v[0], lo_v[0]);

    // Reset in the twentieth BUSY cycle.
    @(posedge clock); #1;
    a_v[0] = 32'hDEADBEEF; b_v[0] = 32'h12345; sg_v[0] = 1'b1; start_v[0] = 1'b1;
    repeat (20) @(posedge clock);
    #1 reset = 1'b1; start_v[0] = 1'b0;
    @(posedge clock); #1 reset = 1'b0;
    @(negedge clock);
    check("midreset stall", 64'(stall_v[0]), 64'd0);
    check("midreset done", 64'(done_v[0]), 64'd0);
    check("midreset product", {hi_v[0], lo_v[0]}, 64'd0);
    $display("reset at busy cycle 20, hi=%h lo=%h", hi_v[0], lo_v[0]);

    // Random operands on every BITS_PER_CYCLE variant.
    for (int k = 0; k < 3; k++) begin
      for (int n = 0; n < 12; n++) begin
        ra = $urandom;
        rb = $urandom;
        rs = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 4) == 0) ra = 32'h80000000;
        if ($urandom_range(0, 4) == 0) rb = 32'hFFFFFFFF;
        if ($urandom_range(0, 9) == 0) rb = 32'h0;
        do_mul(k, ra, rb, rs, ref_mul(ra, rb, rs), $sformatf("rand k%0d n%0d", k, n));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
